dbus_responder: RTL and testbench
=================================

# dbus_responder

Memory-side responder for the core's data bus: it answers the load/store requests the MEM stage issues from `MemRead`/`MemWrite`/`MemSize`. The block accepts one request at a time, models a fixed access latency, commits byte-masked writes into an internal word array, and returns full 64-bit read words. It is used as the data-memory model in simulation and as the stand-in for the cache in unit benches of the MEM stage.

## Interface
Parameters:
- `DEPTH`, 1024: number of 64-bit words in the array; power of two, ≥2.
- `LATENCY`, 2: cycles between the `addr_ok` cycle and the `data_ok` cycle; legal range 1..15.

Ports:
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-low; asserted when 0, sampled on `clk`.
- `req_valid`  in  1  initiator has a request.
- `req_addr`  in  64  byte address.
- `req_strobe`  in  8  byte-lane write enables; nonzero means write, zero means read.
- `req_data`  in  64  write data, lane-aligned: byte i on bits [8i+7:8i].
- `addr_ok`  out  1  request accepted; one-cycle pulse.
- `data_ok`  out  1  access complete; one-cycle pulse.
- `resp_data`  out  64  read word; valid only while `data_ok`=1.

## Operation
- Word index = `req_addr[3 +: log2(DEPTH)]`; `req_addr[2:0]` and bits above the index are ignored, so out-of-range addresses alias modulo DEPTH.
- Size and alignment are encoded by the initiator in `req_strobe` and consumed from `resp_data` by WB extraction. The responder never shifts or extends data.
- States:
  - IDLE: `req_valid`=1 latches addr, strobe and data, loads cnt=LATENCY-1, and moves to WAIT.
  - WAIT: cnt≠0 decrements and stays in WAIT; cnt=0 moves to RESP.
  - RESP: always returns to IDLE.
- Outputs are registered:
  - `addr_ok`=1 exactly in the first WAIT cycle.
  - `data_ok`=1 exactly in the RESP cycle.
  - `resp_data` holds the array word at the latched index during RESP and is 0 otherwise.
- Write commit: on the clock edge that enters RESP, every lane with a strobe bit set is written into the array; other lanes are unchanged. For writes, `resp_data` in RESP shows the post-write word.
- Request fields are latched at acceptance; the initiator may change or drop them after the accept edge.
- `req_valid` in WAIT or RESP is ignored (not queued). The initiator must hold it until `addr_ok`.

## Timing
- Accept edge at end of cycle T: `addr_ok` at T+1, `data_ok` at T+1+LATENCY.
- The next request is sampled no earlier than T+2+LATENCY (first IDLE cycle).
- Back-to-back requests with `req_valid` held high give a throughput of one access per LATENCY+2 cycles.
- Reset (`reset`=0 at an edge), in any state including mid-WAIT:
  - State goes to IDLE; cnt=0; `addr_ok`=0, `data_ok`=0, `resp_data`=0 in the following cycle.
  - A pending, uncommitted write is dropped.
  - Array contents are not cleared.
- Reset value of every output: 0.
- With `reset` held at 0, `req_valid` is ignored.

## Structure
- Shared package `pipes`: `typedef enum logic [1:0] {DR_IDLE, DR_WAIT, DR_RESP} dbus_resp_state_t`.
- Natural sub-module: `dbus_byte_ram`, a DEPTH×64 array with a synchronous byte-masked write port (8-bit mask) and an asynchronous read port.
- The top contains the FSM, the latency counter (width 4) and the request latches.

## Test plan
- Read after reset: array preloaded with word[5]=0x1122334455667788; request addr 0x28, strobe 0, LATENCY=2, accepted at T. Expect `addr_ok` at T+1, `data_ok` at T+3 with `resp_data`=0x1122334455667788, and `resp_data`=0 at T+2 and T+4.
- Partial write: word[5] as above, then write addr 0x2D, strobe 0x30, data 0x0000AABB00000000. Expect `data_ok` with 0x1122AABB55667788; a following read returns the same value.
- Aliasing: DEPTH=1024, write addr 0x2008 with strobe 0xFF, data 0xDEADBEEF. Expect a read of addr 0x0008 to return 0x00000000DEADBEEF.
- Held valid: `req_valid` held high for 20 cycles with LATENCY=1. Expect `addr_ok` pulses exactly 3 cycles apart and no `data_ok` without a preceding `addr_ok`.
- Reset mid-WAIT: LATENCY=5, write strobe 0xFF, data 0xFFFF to word 3 (old value 0), with reset=0 asserted 2 cycles after `addr_ok`. Expect no `data_ok`, all outputs 0 the cycle after the reset edge, and a read of word 3 returning 0.
- LATENCY=15 boundary: expect exactly 15 cycles from `addr_ok` to `data_ok` with no counter wrap.

Source files
------------

// File: rtl/dbus_responder_pkg.sv
// Shared types and helpers for the data-bus responder.
package pipes;

   typedef enum logic [1:0] {DR_IDLE, DR_WAIT, DR_RESP} dbus_resp_state_t;

   localparam int unsigned CntW  = 4;
   localparam int unsigned LaneN = 8;

   // Overlay the strobed byte lanes of new_word onto old_word.
   function automatic logic [63:0] lane_merge(input logic [63:0]      old_word,
                                              input logic [63:0]      new_word,
                                              input logic [LaneN-1:0] strobe);
      logic [63:0] w;
      w = old_word;
      for (int b = 0; b < LaneN; b++) begin
         if (strobe[b]) w[8*b +: 8] = new_word[8*b +: 8];
      end
      return w;
   endfunction

endpackage

// File: rtl/dbus_responder_ram.sv
// DEPTH x 64 word array: synchronous byte-masked write, asynchronous read.
module dbus_byte_ram
   import pipes::*;
#(
   parameter int unsigned DEPTH = 1024,
   localparam int unsigned IdxW = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             wr_en_i,
   input  logic [IdxW-1:0]  wr_idx_i,
   input  logic [LaneN-1:0] wr_strobe_i,
   input  logic [63:0]      wr_data_i,
   input  logic [IdxW-1:0]  rd_idx_i,
   output logic [63:0]      rd_data_o
);

   logic [63:0] mem_q [DEPTH];

   // Byte-lane write; contents are deliberately never reset.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         for (int b = 0; b < LaneN; b++) begin
            if (wr_strobe_i[b]) mem_q[wr_idx_i][8*b +: 8] <= wr_data_i[8*b +: 8];
         end
      end
   end

   assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/dbus_responder.sv
// Memory-side data-bus responder: one request at a time, fixed latency, byte-masked writes.
module dbus_responder
   import pipes::*;
#(
   parameter int unsigned DEPTH   = 1024,
   parameter int unsigned LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic [63:0] req_addr,
   input  logic [7:0]  req_strobe,
   input  logic [63:0] req_data,
   output logic        addr_ok,
   output logic        data_ok,
   output logic [63:0] resp_data
);

   localparam int unsigned IdxW = $clog2(DEPTH);

   dbus_resp_state_t state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [IdxW-1:0]  idx_q;
   logic [7:0]       strobe_q;
   logic [63:0]      data_q;
   logic             addr_ok_q, addr_ok_d;
   logic             data_ok_q, data_ok_d;
   logic [63:0]      resp_data_q, resp_data_d;
   logic             accept;
   logic             wr_en;
   logic [63:0]      rd_word;
   logic             unused_addr;

   // Offset bits and bits above the index are ignored, so addresses alias modulo DEPTH.
   assign unused_addr = ^{req_addr[63:3+IdxW], req_addr[2:0]};

   assign accept = (state_q == DR_IDLE) && req_valid;

   // State, counter and registered outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= DR_IDLE;
         cnt_q       <= '0;
         addr_ok_q   <= 1'b0;
         data_ok_q   <= 1'b0;
         resp_data_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_ok_q   <= addr_ok_d;
         data_ok_q   <= data_ok_d;
         resp_data_q <= resp_data_d;
      end
   end

   // Request fields captured at acceptance so the initiator may move on.
   always_ff @(posedge clk) begin
      if (!reset) begin
         idx_q    <= '0;
         strobe_q <= '0;
         data_q   <= '0;
      end else if (accept) begin
         idx_q    <= req_addr[3 +: IdxW];
         strobe_q <= req_strobe;
         data_q   <= req_data;
      end
   end

   // Next-state and latency countdown.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         DR_IDLE: begin
            if (req_valid) begin
               state_d = DR_WAIT;
               cnt_d   = CntW'(LATENCY - 1);
            end
         end
         DR_WAIT: begin
            if (cnt_q != '0) cnt_d = cnt_q - CntW'(1);
            else             state_d = DR_RESP;
         end
         DR_RESP: state_d = DR_IDLE;
         default: state_d = DR_IDLE;
      endcase
   end

   // Output next-values and write commit on the edge that enters RESP.
   always_comb begin
      addr_ok_d   = 1'b0;
      data_ok_d   = 1'b0;
      resp_data_d = '0;
      wr_en       = 1'b0;
      if (accept) addr_ok_d = 1'b1;
      if ((state_q == DR_WAIT) && (cnt_q == '0)) begin
         data_ok_d   = 1'b1;
         // rd_word is still the pre-write word here; merge to present the post-write value.
         resp_data_d = lane_merge(rd_word, data_q, strobe_q);
         // A reset on this edge drops the pending write.
         wr_en       = reset;
      end
   end

   dbus_byte_ram #(
      .DEPTH (DEPTH)
   ) u_ram (
      .clk_i       (clk),
      .wr_en_i     (wr_en),
      .wr_idx_i    (idx_q),
      .wr_strobe_i (strobe_q),
      .wr_data_i   (data_q),
      .rd_idx_i    (idx_q),
      .rd_data_o   (rd_word)
   );

   assign addr_ok   = addr_ok_q;
   assign data_ok   = data_ok_q;
   assign resp_data = resp_data_q;

endmodule

// File: tb/tb_dbus_responder.sv
// Bench for dbus_responder: four instances at LATENCY 2, 1, 5 and 15.
module tb_dbus_responder;

   localparam int NDut = 4;
   localparam int LATS [NDut] = '{2, 1, 5, 15};
   localparam int Depth = 1024;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid  [NDut];
   logic [63:0] req_addr   [NDut];
   logic [7:0]  req_strobe [NDut];
   logic [63:0] req_data   [NDut];
   logic        addr_ok    [NDut];
   logic        data_ok    [NDut];
   logic [63:0] resp_data  [NDut];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NDut; g++) begin : g_dut
      dbus_responder #(
         .DEPTH   (Depth),
         .LATENCY (LATS[g])
      ) u_dut (
         .clk        (clk),
         .reset      (reset),
         .req_valid  (req_valid[g]),
         .req_addr   (req_addr[g]),
         .req_strobe (req_strobe[g]),
         .req_data   (req_data[g]),
         .addr_ok    (addr_ok[g]),
         .data_ok    (data_ok[g]),
         .resp_data  (resp_data[g])
      );
   end

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   // Reference memory: one word array per instance, written by byte-lane masking.
   logic [63:0] mdl [NDut][Depth];

   function automatic logic [63:0] apply_write(input logic [63:0] old_w, input logic [63:0] new_w,
                                               input logic [7:0] strb);
      logic [63:0] m;
      m = '0;
      for (int i = 0; i < 8; i++) begin
         if (strb[i]) m = m | (64'hFF << (8 * i));
      end
      return (old_w & ~m) | (new_w & m);
   endfunction

   // One request on instance d, starting from an IDLE cycle at a negedge; checks the full timeline.
   task automatic txn(input int d, input logic [63:0] addr, input logic [7:0] strb,
                      input logic [63:0] wdata, input logic [63:0] exp, input string tag);
      int n;
      bit seen;
      int lat;
      lat = LATS[d];
      req_addr[d]   = addr;
      req_strobe[d] = strb;
      req_data[d]   = wdata;
      req_valid[d]  = 1'b1;
      seen = 1'b0;
      n = 0;
      while (!seen && n < 8) begin
         @(negedge clk);
         n++;
         seen = (addr_ok[d] === 1'b1);
      end
      chk({tag, " accept cycles"}, 128'(n), 128'(1));
      req_valid[d]  = 1'b0;
      req_addr[d]   = {$urandom, $urandom};
      req_strobe[d] = 8'($urandom);
      req_data[d]   = {$urandom, $urandom};
      if (!seen) return;
      for (int k = 1; k <= lat; k++) begin
         @(negedge clk);
         if (k < lat) begin
            chk({tag, " wait quiet"}, 128'({addr_ok[d], data_ok[d], resp_data[d]}), 128'(0));
         end else begin
            chk({tag, " data_ok"}, 128'({addr_ok[d], data_ok[d]}), 128'(2'b01));
            chk({tag, " resp_data"}, 128'(resp_data[d]), 128'(exp));
         end
      end
      @(negedge clk);
      chk({tag, " after resp"}, 128'({addr_ok[d], data_ok[d], resp_data[d]}), 128'(0));
   endtask

   typedef struct {
      int          d;
      logic [63:0] addr;
      logic [7:0]  strb;
      logic [63:0] data;
      logic [63:0] exp;
   } vec_t;

   localparam int NVec = 13;
   vec_t vecs [NVec];
   int   ao_q  [$];
   int   dok_q [$];

   initial begin
      logic [63:0] addr, data, exp;
      logic [7:0]  strb;
      int          w, idx;
      bit          found;

      vecs[0]  = '{0, 64'h28,   8'hFF, 64'h1122334455667788, 64'h1122334455667788};
      vecs[1]  = '{0, 64'h28,   8'h00, 64'h0,                64'h1122334455667788};
      vecs[2]  = '{0, 64'h2D,   8'h30, 64'h0000AABB00000000, 64'h1122AABB55667788};
      vecs[3]  = '{0, 64'h28,   8'h00, 64'h0,                64'h1122AABB55667788};
      vecs[4]  = '{0, 64'h2008, 8'hFF, 64'h00000000DEADBEEF, 64'h00000000DEADBEEF};
      vecs[5]  = '{0, 64'h0008, 8'h00, 64'h0,                64'h00000000DEADBEEF};
      vecs[6]  = '{1, 64'h10,   8'hFF, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF};
      vecs[7]  = '{1, 64'h12,   8'h00, 64'h0,                64'h0123456789ABCDEF};
      vecs[8]  = '{3, 64'h18,   8'hFF, 64'hCAFEF00D12345678, 64'hCAFEF00D12345678};
      vecs[9]  = '{3, 64'h1F,   8'h81, 64'hEE000000000000FF, 64'hEEFEF00D123456FF};
      vecs[10] = '{3, 64'h18,   8'h00, 64'h0,                64'hEEFEF00D123456FF};
      vecs[11] = '{2, 64'h7FF8, 8'hFF, 64'h5555AAAA5555AAAA, 64'h5555AAAA5555AAAA};
      vecs[12] = '{2, 64'hFFF8, 8'h00, 64'h0,                64'h5555AAAA5555AAAA};

      // Reset with req_valid high: requests must be ignored.
      reset = 1'b0;
      for (int d = 0; d < NDut; d++) begin
         req_valid[d]  = 1'b1;
         req_addr[d]   = 64'h28;
         req_strobe[d] = 8'h00;
         req_data[d]   = 64'h0;
      end
      repeat (3) @(negedge clk);
      for (int d = 0; d < NDut; d++) begin
         chk($sformatf("reset outputs d%0d", d),
             128'({addr_ok[d], data_ok[d], resp_data[d]}), 128'(0));
         req_valid[d] = 1'b0;
      end
      reset = 1'b1;

      // Directed vectors from the test plan.
      for (int i = 0; i < NVec; i++) begin
         txn(vecs[i].d, vecs[i].addr, vecs[i].strb, vecs[i].data, vecs[i].exp,
             $sformatf("vec%0d", i));
      end

      // Held valid on LATENCY=1: accepts every 3 cycles, data_ok one cycle after each addr_ok.
      req_addr[1]   = 64'h10;
      req_strobe[1] = 8'h00;
      req_valid[1]  = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (addr_ok[1]) ao_q.push_back(c);
         if (data_ok[1]) begin
            dok_q.push_back(c);
            chk("held resp_data", 128'(resp_data[1]), 128'(64'h0123456789ABCDEF));
         end
      end
      req_valid[1] = 1'b0;
      chk("held addr_ok count", 128'(ao_q.size()), 128'(7));
      chk("held data_ok count", 128'(dok_q.size()), 128'(7));
      for (int i = 1; i < ao_q.size(); i++) begin
         chk("held addr_ok spacing", 128'(ao_q[i] - ao_q[i-1]), 128'(3));
      end
      for (int i = 0; i < dok_q.size(); i++) begin
         found = 1'b0;
         foreach (ao_q[j]) if (ao_q[j] == dok_q[i] - 1) found = 1'b1;
         chk("held data_ok preceded", 128'(found), 128'(1));
      end
      @(negedge clk);

      // Reset two cycles after addr_ok on LATENCY=5: write dropped, array kept.
      txn(2, 64'h18, 8'hFF, 64'h0, 64'h0, "rst pre");
      req_addr[2]   = 64'h18;
      req_strobe[2] = 8'hFF;
      req_data[2]   = 64'hFFFF;
      req_valid[2]  = 1'b1;
      @(negedge clk);
      chk("rst addr_ok", 128'(addr_ok[2]), 128'(1));
      req_valid[2] = 1'b0;
      @(negedge clk);
      chk("rst data_ok A+1", 128'(data_ok[2]), 128'(0));
      @(negedge clk);
      chk("rst data_ok A+2", 128'(data_ok[2]), 128'(0));
      reset = 1'b0;
      @(negedge clk);
      for (int d = 0; d < NDut; d++) begin
         chk($sformatf("rst outputs d%0d", d),
             128'({addr_ok[d], data_ok[d], resp_data[d]}), 128'(0));
      end
      reset = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         chk("rst no data_ok", 128'(data_ok[2]), 128'(0));
      end
      txn(2, 64'h18, 8'h00, 64'h0, 64'h0, "rst read");

      // Random traffic against the reference memory, with aliased upper bits and offsets.
      for (int d = 0; d < NDut; d++) begin
         for (int k = 0; k < 16; k++) begin
            data = {$urandom, $urandom};
            addr = 64'(k) * 8;
            txn(d, addr, 8'hFF, data, data, $sformatf("init d%0d w%0d", d, k));
            mdl[d][k] = data;
         end
         for (int t = 0; t < 40; t++) begin
            w    = int'($urandom_range(15));
            addr = ({$urandom, $urandom} << 13) | (64'(w) << 3) | 64'($urandom_range(7));
            strb = ($urandom_range(2) == 0) ? 8'h00 : 8'($urandom);
            data = {$urandom, $urandom};
            idx  = int'((addr / 8) % Depth);
            exp  = apply_write(mdl[d][idx], data, strb);
            mdl[d][idx] = exp;
            txn(d, addr, strb, data, exp, $sformatf("rnd d%0d t%0d", d, t));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
